// File: rtl/win_scan_ctrl.sv
// Sequencing controller for the 3x3 sliding-window filter: raster-scans window
// origins, delays each read by the filter latency to produce writebacks, then signals done.
module win_scan_ctrl #(
  parameter int unsigned IMG_W    = 64,
  parameter int unsigned IMG_H    = 64,
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              rd,
  output logic [ADDR_W-1:0] rd_row,
  output logic [ADDR_W-1:0] rd_col,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_row,
  output logic [ADDR_W-1:0] wr_col
);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_issue;
  logic              w_shift;
  logic              w_at_end;
  logic              w_tail_last;

  logic [ADDR_W-1:0] r_cnt_row;
  logic [ADDR_W-1:0] r_cnt_col;

  // Latency tracker: entry 0 receives the read issued this cycle, the tail feeds wr.
  logic [PIPE_LAT-1:0] r_dl_vld;
  logic [ADDR_W-1:0]   r_dl_row [PIPE_LAT];
  logic [ADDR_W-1:0]   r_dl_col [PIPE_LAT];

  logic              r_busy;
  logic              r_done;
  logic              r_rd;
  logic [ADDR_W-1:0] r_rd_row;
  logic [ADDR_W-1:0] r_rd_col;
  logic              r_wr;
  logic [ADDR_W-1:0] r_wr_row;
  logic [ADDR_W-1:0] r_wr_col;

  // Next-state and per-cycle control decode
  always_comb begin
    w_next      = r_state;
    w_issue     = 1'b0;
    w_shift     = 1'b0;
    w_at_end    = (r_cnt_row == LAST_ROW) && (r_cnt_col == LAST_COL);
    w_tail_last = r_dl_vld[PIPE_LAT-1] &&
                  (r_dl_row[PIPE_LAT-1] == LAST_ROW) &&
                  (r_dl_col[PIPE_LAT-1] == LAST_COL);
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SCAN;
      end
      S_SCAN: begin
        w_issue = !stall;
        w_shift = !stall;
        if (!stall && w_at_end) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_shift = !stall;
        if (!stall && w_tail_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt_row <= '0;
      r_cnt_col <= '0;
      r_dl_vld  <= '0;
      for (int i = 0; i < int'(PIPE_LAT); i++) begin
        r_dl_row[i] <= '0;
        r_dl_col[i] <= '0;
      end
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd      <= 1'b0;
      r_rd_row  <= '0;
      r_rd_col  <= '0;
      r_wr      <= 1'b0;
      r_wr_row  <= '0;
      r_wr_col  <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (r_state == S_SCAN) || (r_state == S_DRAIN);
      r_done  <= (r_state == S_DONE);
      r_rd    <= w_issue;

      if ((r_state == S_IDLE) && start) begin
        r_cnt_row <= '0;
        r_cnt_col <= '0;
      end else if (w_issue) begin
        r_rd_row <= r_cnt_row;
        r_rd_col <= r_cnt_col;
        if (r_cnt_col == LAST_COL) begin
          r_cnt_col <= '0;
          r_cnt_row <= r_cnt_row + ADDR_W'(1);
        end else begin
          r_cnt_col <= r_cnt_col + ADDR_W'(1);
        end
      end

      // A stalled cycle holds the line and suppresses wr; the tail reappears afterwards
      if (w_shift) begin
        r_wr        <= r_dl_vld[PIPE_LAT-1];
        r_wr_row    <= r_dl_row[PIPE_LAT-1];
        r_wr_col    <= r_dl_col[PIPE_LAT-1];
        for (int i = int'(PIPE_LAT) - 1; i > 0; i--) begin
          r_dl_vld[i] <= r_dl_vld[i-1];
          r_dl_row[i] <= r_dl_row[i-1];
          r_dl_col[i] <= r_dl_col[i-1];
        end
        r_dl_vld[0] <= w_issue;
        r_dl_row[0] <= r_cnt_row;
        r_dl_col[0] <= r_cnt_col;
      end else begin
        r_wr <= 1'b0;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign rd     = r_rd;
  assign rd_row = r_rd_row;
  assign rd_col = r_rd_col;
  assign wr     = r_wr;
  assign wr_row = r_wr_row;
  assign wr_col = r_wr_col;

endmodule

// File: tb/tb_win_scan_ctrl.sv
// Scoreboard bench for win_scan_ctrl: a 4x3 (latency 2) instance under directed and
// random stimulus, and a default-size instance sweeping one full 64x64 frame.
module tb_win_scan_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd;
    logic       wr;
    logic       chk_rd;
    logic       chk_wr;
    logic [6:0] rd_row;
    logic [6:0] rd_col;
    logic [6:0] wr_row;
    logic [6:0] wr_col;
  } exp_t;

  typedef struct packed {
    logic [1:0] phase;   // 0 idle, 1 frame in progress, 2 done pulse pending
    int         a;       // non-stalled cycles since frame start
  } mstate_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stall, b_start;
  logic       s_busy, s_done, s_rd, s_wr;
  logic [6:0] s_rd_row, s_rd_col, s_wr_row, s_wr_col;
  logic       b_busy, b_done, b_rd, b_wr;
  logic [6:0] b_rd_row, b_rd_col, b_wr_row, b_wr_col;

  win_scan_ctrl #(.IMG_W(4), .IMG_H(3), .PIPE_LAT(2), .ADDR_W(7)) u_small (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(s_busy), .done(s_done), .rd(s_rd), .rd_row(s_rd_row), .rd_col(s_rd_col),
    .wr(s_wr), .wr_row(s_wr_row), .wr_col(s_wr_col)
  );

  win_scan_ctrl u_big (
    .clk(clk), .rst(rst), .start(b_start), .stall(1'b0),
    .busy(b_busy), .done(b_done), .rd(b_rd), .rd_row(b_rd_row), .rd_col(b_rd_col),
    .wr(b_wr), .wr_row(b_wr_row), .wr_col(b_wr_col)
  );

  exp_t    q_s[$];
  exp_t    q_b[$];
  mstate_t ms_s, ms_b;
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  logic    end_req = 1'b0;

  // Reference: the k-th non-stalled cycle of a frame reads raster pixel k-1 and
  // writes back raster pixel k-1-lat; one cycle after the last write comes done.
  function automatic void model_step(input int w, input int h, input int lat,
                                     input mstate_t si, input logic r, input logic s,
                                     input logic st, output mstate_t so, output exp_t e);
    int n;
    n  = w * h;
    e  = '0;
    so = si;
    if (r) begin
      so.phase = 2'd0;
      so.a     = 0;
      e.chk_rd = 1'b1;
      e.chk_wr = 1'b1;
    end else begin
      case (si.phase)
        2'd0: if (s) begin
          so.phase = 2'd1;
          so.a     = 0;
        end
        2'd1: begin
          e.busy = 1'b1;
          if (!st) begin
            so.a = si.a + 1;
            if (so.a <= n) begin
              e.rd     = 1'b1;
              e.chk_rd = 1'b1;
              e.rd_row = 7'((so.a - 1) / w);
              e.rd_col = 7'((so.a - 1) % w);
            end
            if (so.a > lat && so.a - lat <= n) begin
              e.wr     = 1'b1;
              e.chk_wr = 1'b1;
              e.wr_row = 7'((so.a - lat - 1) / w);
              e.wr_col = 7'((so.a - lat - 1) % w);
            end
            if (so.a == n + lat) so.phase = 2'd2;
          end
        end
        default: begin
          e.done   = 1'b1;
          so.phase = 2'd0;
        end
      endcase
    end
  endfunction

  task automatic step(input logic s_rst, input logic s_start, input logic s_stall,
                      input logic s_bstart);
    exp_t    e;
    mstate_t n;
    @(negedge clk);
    rst     = s_rst;
    start   = s_start;
    stall   = s_stall;
    b_start = s_bstart;
    model_step(4, 3, 2, ms_s, s_rst, s_start, s_stall, n, e);
    ms_s = n;
    q_s.push_back(e);
    model_step(64, 64, 3, ms_b, s_rst, s_bstart, 1'b0, n, e);
    ms_b = n;
    q_b.push_back(e);
    @(posedge clk);
  endtask

  task automatic compare(input string nm, input exp_t e, input logic a_busy,
                         input logic a_done, input logic a_rd, input logic a_wr,
                         input logic [6:0] arr, input logic [6:0] arc,
                         input logic [6:0] awr, input logic [6:0] awc);
    logic bad;
    bad = (a_busy !== e.busy) || (a_done !== e.done) || (a_rd !== e.rd) || (a_wr !== e.wr) ||
          (e.chk_rd && ((arr !== e.rd_row) || (arc !== e.rd_col))) ||
          (e.chk_wr && ((awr !== e.wr_row) || (awc !== e.wr_col)));
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s cycle %0d got busy=%b done=%b rd=%b(%0d,%0d) wr=%b(%0d,%0d) expected busy=%b done=%b rd=%b(%0d,%0d) wr=%b(%0d,%0d)",
               nm, cyc, a_busy, a_done, a_rd, arr, arc, a_wr, awr, awc,
               e.busy, e.done, e.rd, e.rd_row, e.rd_col, e.wr, e.wr_row, e.wr_col);
    end
  endtask

  // Monitor: one expected entry per clock edge for each instance
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc = cyc + 1;
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      compare("small", e, s_busy, s_done, s_rd, s_wr, s_rd_row, s_rd_col, s_wr_row, s_wr_col);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      compare("big", e, b_busy, b_done, b_rd, b_wr, b_rd_row, b_rd_col, b_wr_row, b_wr_col);
    end
    if (end_req) begin
      checks++;
      if (q_s.size() != 0 || q_b.size() != 0) begin
        errors++;
        $display("FAIL drain_queues got %0d/%0d entries left expected 0/0", q_s.size(), q_b.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; b_start = 1'b0;
    ms_s = '0; ms_b = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    // Plain frame on both instances; the 64x64 sweep finishes at cycle 4100
    step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4110) step(1'b0, 1'b0, 1'b0, 1'b0);
    // Stall during row transition
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 22; k++) step(1'b0, 1'b0, (k >= 5 && k <= 7), 1'b0);
    // Start re-pulsed mid-frame and on the done cycle
    for (int k = 0; k <= 19; k++) step(1'b0, (k == 0 || k == 4 || k == 10 || k == 15), 1'b0, 1'b0);
    repeat (40) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0);
    // Reset mid-frame, then a fresh frame
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (18) step(1'b0, 1'b0, 1'b0, 1'b0);
    // Stall held through the drain
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 25; k++) step(1'b0, 1'b0, (k >= 13 && k <= 17), 1'b0);
    // Random traffic
    repeat (600) step(($urandom % 60) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0, 1'b0);
    end_req = 1'b1;
  end

endmodule
